button_encoder: RTL

BUTTON_ENCODER -- requirements
Module: button_encoder

---
 rtl/button_encoder_pkg.sv | 30 +++
 rtl/button_debounce.sv | 40 ++++
 rtl/button_encoder.sv | 57 +++++
 3 files changed

// File: rtl/button_encoder_pkg.sv
// rtl/button_encoder_pkg.sv - shared constants and helpers for the button encoder
package button_encoder_pkg;

  localparam int NUM_BTN = 4;

  // Encoder FSM state encodings, kept alongside the other controller state constants
  localparam logic ENC_ARMED_S = 1'b0;
  localparam logic ENC_HELD_S  = 1'b1;

  typedef enum logic {
    ARMED = ENC_ARMED_S,
    HELD  = ENC_HELD_S
  } enc_state_t;

  // True when exactly one button level is high
  function automatic logic is_single(input logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Index of the lowest set bit; only meaningful when is_single() holds
  function automatic logic [1:0] btn_index(input logic [NUM_BTN-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (v[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchronizer plus counter debounce for one button
module button_debounce #(
  parameter int DB_COUNT = 50000,
  parameter int DB_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_COUNT - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // Synchronize the raw level, then accept a change only after DB_COUNT agreeing cycles;
  // any return to the stable level restarts the window, and the counter never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_encoder.sv
// rtl/button_encoder.sv - debounced four-button to colour-index encoder with press pulse
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int DB_COUNT = 50000,
  parameter int DB_W     = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  output logic [1:0] IN,
  output logic       IN_VALID
);

  logic [NUM_BTN-1:0] stable;
  enc_state_t         state;

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_db
    button_debounce #(
      .DB_COUNT(DB_COUNT),
      .DB_W    (DB_W)
    ) u_db (
      .clk   (CLK),
      .rst_n (RST_N),
      .raw   (BTN[k]),
      .stable(stable[k])
    );
  end

  // Pulse once for a lone press from ARMED; chords and presses while held stay silent
  // until every debounced button is released again
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ARMED;
      IN       <= 2'd0;
      IN_VALID <= 1'b0;
    end else begin
      IN_VALID <= 1'b0;
      case (state)
        ARMED: begin
          if (is_single(stable)) begin
            IN       <= btn_index(stable);
            IN_VALID <= 1'b1;
            state    <= HELD;
          end else if (stable != '0) begin
            state <= HELD;
          end
        end
        HELD: begin
          if (stable == '0) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule
